dispatch_unit: RTL and testbench
================================

Name: dispatch_unit

Overview:
- Writer side of the issue queue. Accepts renamed instructions from the rename stage over a valid/ready handshake and buffers them in a small FIFO.
- Reads source operand values from the physical register file and allocates ROB indices in order.
- Drives registered write_enable/operand fields into the issue queue, stalling on issue_queue_full or ROB full. Sits between rename and issue_queue.

Parameters:
- DEPTH, 4, skid FIFO entries (power of 2, >=2)
- ROB_SIZE, 64, ROB entries; ROB index wraps modulo ROB_SIZE
- PREG_BITS, 6, physical register tag width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (branch mispredict), synchronous
- in_valid  in  1  rename has an instruction
- in_ready  out  1  dispatch can accept this cycle
- in_opcode  in  7  RISC-V opcode
- in_phys_dest  in  PREG_BITS  destination physical tag
- in_phys_rs1  in  PREG_BITS  source 1 physical tag
- in_phys_rs2  in  PREG_BITS  source 2 physical tag
- in_immediate  in  32  sign-extended immediate
- prf_rs1_addr  out  PREG_BITS  PRF read address 1 = FIFO head rs1 (combinational)
- prf_rs2_addr  out  PREG_BITS  PRF read address 2 = FIFO head rs2 (combinational)
- prf_rs1_data  in  32  PRF read data 1 (combinational read)
- prf_rs2_data  in  32  PRF read data 2
- rob_alloc_ok  in  1  ROB has a free entry
- rob_alloc  out  1  ROB allocate pulse, same cycle as dispatch decision
- issue_queue_full  in  1  issue queue cannot accept
- write_enable  out  1  registered write strobe to issue queue
- phys_dest, phys_rs1, phys_rs2  out  PREG_BITS each  registered tags
- phys_rs1_val, phys_rs2_val  out  32 each  registered operand values
- opcode  out  7  registered opcode
- immediate  out  32  registered immediate
- ROB_entry_index  out  log2(ROB_SIZE)  registered ROB index

Behaviour:
- Reset (reset=1 at edge):
  - FIFO empty; count=0; ROB index counter=0.
  - All registered outputs 0.
  - in_ready=0 and rob_alloc=0 while reset is high.
- in_ready = !reset && !flush && (count < DEPTH). Push occurs on an edge where in_valid && in_ready; fields are written at the tail.
- No push when full, even if a pop occurs in the same cycle (in_ready depends only on current count).
- Dispatch condition D (combinational) = count>0 && !issue_queue_full && rob_alloc_ok && !flush && !reset.
- rob_alloc = D.
- At the edge where D=1:
  - Pop head.
  - write_enable<=1.
  - Tag/opcode/immediate registers <= head fields.
  - ROB_entry_index <= counter; counter <= (counter+1) mod ROB_SIZE (wraps ROB_SIZE-1 -> 0).
  - phys_rs1_val <= (head rs1==0) ? 0 : prf_rs1_data; same rule for rs2 (x0 forced zero).
- At an edge where D=0: write_enable<=0; all other output registers hold their previous values.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- Latency: an instruction accepted at edge k into an empty FIFO gives D=1 in cycle k (if not stalled), so write_enable is high for exactly one cycle starting at edge k+1. Minimum 1 cycle, 1 instruction/cycle sustained.
- Stall: issue_queue_full or !rob_alloc_ok holds the head in place, with no loss and no duplication; order is strictly FIFO.
- Flush at edge:
  - FIFO emptied; count=0; ROB index counter=0; write_enable<=0.
  - Any push presented that cycle is dropped (in_ready was 0).
- Reset or flush mid-stall: queued entries are discarded and never written to the issue queue.

Test Plan:
- Reset, then push ADD (opcode 0110011, dest 1, rs1 2, rs2 3, PRF data 42/17) at edge k -> write_enable=1 for one cycle at k+1, phys_rs1_val=42, phys_rs2_val=17, ROB_entry_index=0.
- Push SUB with rs2=0 and prf_rs2_data=0xDEADBEEF -> phys_rs2_val=0. Then LW (0000011, imm 8) -> ROB_entry_index=1, immediate=8.
- Hold issue_queue_full=1 and push 4 instructions -> in_ready drops to 0 after the 4th and write_enable stays 0. Release -> 4 consecutive write_enable cycles in push order, ROB indices 0..3.
- rob_alloc_ok=0 for 3 cycles with 2 queued entries -> no rob_alloc and no write. Then both entries issue back-to-back.
- Dispatch 65 instructions -> ROB_entry_index sequence 0..63, then 0.
- Flush with 3 queued entries -> nothing further written. Next pushed instruction gets ROB_entry_index=0 and appears one cycle after its accept.

Source files
------------

// File: rtl/dispatch_unit_if.sv
// Rename-to-dispatch handshake plus the dispatch-to-issue-queue write bus.
// The dispatch unit connects through the slave view. The surrounding
// pipeline (rename stage and issue queue) connects through the master view.
interface dispatch_unit_if #(
  parameter int PREG_BITS = 6,
  parameter int ROB_SIZE  = 64
);
  localparam int ROB_BITS = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

  // Rename stage -> dispatch
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [PREG_BITS-1:0]  in_phys_dest;
  logic [PREG_BITS-1:0]  in_phys_rs1;
  logic [PREG_BITS-1:0]  in_phys_rs2;
  logic [31:0]           in_immediate;

  // Dispatch -> issue queue
  logic                  issue_queue_full;
  logic                  write_enable;
  logic [PREG_BITS-1:0]  phys_dest;
  logic [PREG_BITS-1:0]  phys_rs1;
  logic [PREG_BITS-1:0]  phys_rs2;
  logic [31:0]           phys_rs1_val;
  logic [31:0]           phys_rs2_val;
  logic [6:0]            opcode;
  logic [31:0]           immediate;
  logic [ROB_BITS-1:0]   ROB_entry_index;

  // Dispatch unit view
  modport slave (
    input  in_valid,
    input  in_opcode,
    input  in_phys_dest,
    input  in_phys_rs1,
    input  in_phys_rs2,
    input  in_immediate,
    input  issue_queue_full,
    output in_ready,
    output write_enable,
    output phys_dest,
    output phys_rs1,
    output phys_rs2,
    output phys_rs1_val,
    output phys_rs2_val,
    output opcode,
    output immediate,
    output ROB_entry_index
  );

  // Rename stage / issue queue view
  modport master (
    output in_valid,
    output in_opcode,
    output in_phys_dest,
    output in_phys_rs1,
    output in_phys_rs2,
    output in_immediate,
    output issue_queue_full,
    input  in_ready,
    input  write_enable,
    input  phys_dest,
    input  phys_rs1,
    input  phys_rs2,
    input  phys_rs1_val,
    input  phys_rs2_val,
    input  opcode,
    input  immediate,
    input  ROB_entry_index
  );
endinterface

// File: rtl/dispatch_unit.sv
// Dispatch unit: buffers renamed instructions in a small skid FIFO, reads
// source operands from the PRF for the FIFO head, allocates ROB indices in
// order and writes one instruction per cycle into the issue queue.
module dispatch_unit #(
  parameter int DEPTH     = 4,
  parameter int ROB_SIZE  = 64,
  parameter int PREG_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  dispatch_unit_if.slave       bus,
  output logic [PREG_BITS-1:0] prf_rs1_addr,
  output logic [PREG_BITS-1:0] prf_rs2_addr,
  input  logic [31:0]          prf_rs1_data,
  input  logic [31:0]          prf_rs2_data,
  input  logic                 rob_alloc_ok,
  output logic                 rob_alloc
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int ROB_BITS = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);
  localparam logic [ROB_BITS-1:0] ROB_LAST  = ROB_BITS'(ROB_SIZE - 1);

  // One buffered instruction.
  typedef struct packed {
    logic [6:0]           op;
    logic [PREG_BITS-1:0] dest;
    logic [PREG_BITS-1:0] rs1;
    logic [PREG_BITS-1:0] rs2;
    logic [31:0]          imm;
  } entry_t;

  // FIFO bookkeeping
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q,  count_d;
  logic [ROB_BITS-1:0] rob_idx_q, rob_idx_d;

  // Issue-queue output registers
  logic                 we_q,   we_d;
  entry_t               out_q,  out_d;
  logic [31:0]          rs1_val_q, rs1_val_d;
  logic [31:0]          rs2_val_q, rs2_val_d;
  logic [ROB_BITS-1:0]  out_idx_q, out_idx_d;

  logic   push;
  logic   dispatch;
  entry_t in_entry;
  entry_t head;
  entry_t slot_data [DEPTH];
  logic [DEPTH-1:0] slot_wr;

  // Accept only with free space; a pop in the same cycle does not open a slot.
  assign bus.in_ready = !reset && !flush && (count_q < DEPTH_CNT);
  assign push         = bus.in_valid && bus.in_ready;

  // Head leaves the FIFO only when both the issue queue and the ROB can take it.
  assign dispatch  = (count_q != '0) && !bus.issue_queue_full && rob_alloc_ok
                     && !flush && !reset;
  assign rob_alloc = dispatch;

  assign in_entry.op   = bus.in_opcode;
  assign in_entry.dest = bus.in_phys_dest;
  assign in_entry.rs1  = bus.in_phys_rs1;
  assign in_entry.rs2  = bus.in_phys_rs2;
  assign in_entry.imm  = bus.in_immediate;

  // Each slot is its own register, written when the tail points at it.
  // Slots hold no architectural state, so they need no reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_q;

      assign slot_wr[gi]   = push && (wr_ptr_q == PTR_BITS'(gi));
      assign slot_data[gi] = slot_q;

      // Capture the incoming instruction into this slot.
      always_ff @(posedge clk) begin
        if (slot_wr[gi]) begin
          slot_q <= in_entry;
        end
      end
    end
  endgenerate

  // Head is read combinationally so the PRF lookup happens in the same cycle.
  assign head         = slot_data[rd_ptr_q];
  assign prf_rs1_addr = head.rs1;
  assign prf_rs2_addr = head.rs2;

  // Pointer, occupancy and ROB-index next state; flush discards everything.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rob_idx_d = rob_idx_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rob_idx_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (dispatch) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rob_idx_d = (rob_idx_q == ROB_LAST) ? '0 : rob_idx_q + 1'b1;
      end
      case ({push, dispatch})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Output register next state: load the head on dispatch, otherwise hold.
  always_comb begin
    we_d      = dispatch;
    out_d     = out_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    out_idx_d = out_idx_q;
    if (dispatch) begin
      out_d     = head;
      rs1_val_d = (head.rs1 == '0) ? 32'd0 : prf_rs1_data;
      rs2_val_d = (head.rs2 == '0) ? 32'd0 : prf_rs2_data;
      out_idx_d = rob_idx_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rob_idx_q <= '0;
      we_q      <= 1'b0;
      out_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      out_idx_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rob_idx_q <= rob_idx_d;
      we_q      <= we_d;
      out_q     <= out_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign bus.write_enable    = we_q;
  assign bus.opcode          = out_q.op;
  assign bus.phys_dest       = out_q.dest;
  assign bus.phys_rs1        = out_q.rs1;
  assign bus.phys_rs2        = out_q.rs2;
  assign bus.immediate       = out_q.imm;
  assign bus.phys_rs1_val    = rs1_val_q;
  assign bus.phys_rs2_val    = rs2_val_q;
  assign bus.ROB_entry_index = out_idx_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_unit;
  localparam int DEPTH    = 4;
  localparam int ROB_SIZE = 64;
  localparam int PB       = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [PB-1:0] prf_rs1_addr, prf_rs2_addr;
  logic [31:0]   prf_rs1_data, prf_rs2_data;
  logic          rob_alloc_ok;
  logic          rob_alloc;
  logic [31:0]   prf_mem [64];

  int tests = 0;
  int fails = 0;

  dispatch_unit_if #(.PREG_BITS(PB), .ROB_SIZE(ROB_SIZE)) bus();

  dispatch_unit #(.DEPTH(DEPTH), .ROB_SIZE(ROB_SIZE), .PREG_BITS(PB)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .prf_rs1_addr (prf_rs1_addr),
    .prf_rs2_addr (prf_rs2_addr),
    .prf_rs1_data (prf_rs1_data),
    .prf_rs2_data (prf_rs2_data),
    .rob_alloc_ok (rob_alloc_ok),
    .rob_alloc    (rob_alloc)
  );

  always #5 clk = ~clk;

  // Bench-side register file with combinational read.
  assign prf_rs1_data = prf_mem[prf_rs1_addr];
  assign prf_rs2_data = prf_mem[prf_rs2_addr];

  typedef struct {
    logic [6:0]    op;
    logic [PB-1:0] dest;
    logic [PB-1:0] rs1;
    logic [PB-1:0] rs2;
    logic [31:0]   imm;
  } ins_t;

  // Reference model state
  ins_t        mq[$];
  int          m_rob;
  bit          model_valid = 0;
  logic        e_we;
  logic [6:0]  e_op;
  logic [PB-1:0] e_dest, e_rs1, e_rs2;
  logic [31:0] e_imm, e_v1, e_v2;
  int          e_idx;

  // Observed writes into the issue queue
  int idx_log[$];
  int op_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advance on every rising edge.
  bit   m_rdy, m_d;
  ins_t m_h, m_n;
  initial forever begin
    @(posedge clk);
    m_rdy = !reset && !flush && (mq.size() < DEPTH);
    m_d   = (mq.size() > 0) && !bus.issue_queue_full && rob_alloc_ok && !flush && !reset;
    if (reset) begin
      mq.delete();
      m_rob = 0;
      e_we = 0; e_op = 0; e_dest = 0; e_rs1 = 0; e_rs2 = 0;
      e_imm = 0; e_v1 = 0; e_v2 = 0; e_idx = 0;
      model_valid = 1;
    end else if (flush) begin
      mq.delete();
      m_rob = 0;
      e_we = 0;
    end else begin
      if (m_d) begin
        m_h    = mq.pop_front();
        e_we   = 1;
        e_op   = m_h.op;
        e_dest = m_h.dest;
        e_rs1  = m_h.rs1;
        e_rs2  = m_h.rs2;
        e_imm  = m_h.imm;
        e_v1   = (m_h.rs1 == 0) ? 32'd0 : prf_mem[m_h.rs1];
        e_v2   = (m_h.rs2 == 0) ? 32'd0 : prf_mem[m_h.rs2];
        e_idx  = m_rob;
        m_rob  = (m_rob + 1) % ROB_SIZE;
      end else begin
        e_we = 0;
      end
      if (bus.in_valid && m_rdy) begin
        m_n.op   = bus.in_opcode;
        m_n.dest = bus.in_phys_dest;
        m_n.rs1  = bus.in_phys_rs1;
        m_n.rs2  = bus.in_phys_rs2;
        m_n.imm  = bus.in_immediate;
        mq.push_back(m_n);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  bit c_rdy, c_d;
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      c_rdy = !reset && !flush && (mq.size() < DEPTH);
      c_d   = (mq.size() > 0) && !bus.issue_queue_full && rob_alloc_ok && !flush && !reset;
      chk("in_ready", bus.in_ready, c_rdy);
      chk("rob_alloc", rob_alloc, c_d);
      if (mq.size() > 0) begin
        chk("prf_rs1_addr", prf_rs1_addr, mq[0].rs1);
        chk("prf_rs2_addr", prf_rs2_addr, mq[0].rs2);
      end
      chk("write_enable", bus.write_enable, e_we);
      chk("opcode", bus.opcode, e_op);
      chk("phys_dest", bus.phys_dest, e_dest);
      chk("phys_rs1", bus.phys_rs1, e_rs1);
      chk("phys_rs2", bus.phys_rs2, e_rs2);
      chk("immediate", bus.immediate, e_imm);
      chk("phys_rs1_val", bus.phys_rs1_val, e_v1);
      chk("phys_rs2_val", bus.phys_rs2_val, e_v2);
      chk("rob_index", bus.ROB_entry_index, e_idx);
      if (bus.write_enable === 1'b1) begin
        idx_log.push_back(int'(bus.ROB_entry_index));
        op_log.push_back(int'(bus.opcode));
        $display("[TB] dispatch rob=%0d op=%02h dest=%0d rs1=%0d val=%08h rs2=%0d val=%08h imm=%08h",
                 bus.ROB_entry_index, bus.opcode, bus.phys_dest, bus.phys_rs1,
                 bus.phys_rs1_val, bus.phys_rs2, bus.phys_rs2_val, bus.immediate);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    flush = 0;
    bus.in_valid = 0;
    bus.issue_queue_full = 0;
    rob_alloc_ok = 1;
    repeat (n) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rob_alloc", rob_alloc, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_idx", bus.ROB_entry_index, 0);
    reset = 0;
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic push(input logic [6:0] op, input logic [PB-1:0] d, input logic [PB-1:0] r1,
                      input logic [PB-1:0] r2, input logic [31:0] imm);
    bit acc;
    int n;
    n = 0;
    acc = 0;
    bus.in_valid     = 1;
    bus.in_opcode    = op;
    bus.in_phys_dest = d;
    bus.in_phys_rs1  = r1;
    bus.in_phys_rs2  = r2;
    bus.in_immediate = imm;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got in_ready 0 for %0d cycles, want 1", n);
    end
    bus.in_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    flush = 0;
    rob_alloc_ok = 1;
    bus.in_valid = 0;
    bus.in_opcode = 0;
    bus.in_phys_dest = 0;
    bus.in_phys_rs1 = 0;
    bus.in_phys_rs2 = 0;
    bus.in_immediate = 0;
    bus.issue_queue_full = 0;
    for (int i = 0; i < 64; i++) prf_mem[i] = $urandom;
    prf_mem[0] = 32'hDEADBEEF;
    prf_mem[2] = 32'd42;
    prf_mem[3] = 32'd17;

    // ADD: one-cycle latency, operand values, first ROB index.
    do_reset(2);
    push(7'b0110011, 6'd1, 6'd2, 6'd3, 32'd0);
    chk("add_not_yet", bus.write_enable, 0);
    chk("add_rob_alloc", rob_alloc, 1);
    tick();
    chk("add_we", bus.write_enable, 1);
    chk("add_v1", bus.phys_rs1_val, 42);
    chk("add_v2", bus.phys_rs2_val, 17);
    chk("add_idx", bus.ROB_entry_index, 0);
    tick();
    chk("add_we_once", bus.write_enable, 0);

    // SUB with rs2 = x0, then LW.
    do_reset(1);
    push(7'b0110011, 6'd4, 6'd2, 6'd0, 32'd0);
    tick();
    chk("sub_we", bus.write_enable, 1);
    chk("sub_v2_x0", bus.phys_rs2_val, 0);
    push(7'b0000011, 6'd5, 6'd3, 6'd0, 32'd8);
    tick();
    chk("lw_we", bus.write_enable, 1);
    chk("lw_idx", bus.ROB_entry_index, 1);
    chk("lw_imm", bus.immediate, 8);
    chk("lw_op", bus.opcode, 7'b0000011);

    // Issue queue full: fill the FIFO, then drain in order.
    do_reset(1);
    bus.issue_queue_full = 1;
    push(7'h13, 6'd10, 6'd11, 6'd12, 32'd1);
    push(7'h33, 6'd13, 6'd14, 6'd15, 32'd2);
    push(7'h03, 6'd16, 6'd17, 6'd18, 32'd3);
    push(7'h23, 6'd19, 6'd20, 6'd21, 32'd4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_no_we", bus.write_enable, 0);
    idx_log.delete();
    op_log.delete();
    bus.issue_queue_full = 0;
    repeat (6) tick();
    chk("drain_count", idx_log.size(), 4);
    if (idx_log.size() == 4) begin
      chk("drain_idx0", idx_log[0], 0);
      chk("drain_idx3", idx_log[3], 3);
      chk("drain_op0", op_log[0], 7'h13);
      chk("drain_op3", op_log[3], 7'h23);
    end

    // ROB full for 3 cycles with 2 queued entries.
    do_reset(1);
    rob_alloc_ok = 0;
    push(7'h13, 6'd7, 6'd8, 6'd9, 32'd5);
    push(7'h13, 6'd6, 6'd5, 6'd4, 32'd6);
    for (int i = 0; i < 3; i++) begin
      chk("robfull_no_alloc", rob_alloc, 0);
      chk("robfull_no_we", bus.write_enable, 0);
      tick();
    end
    rob_alloc_ok = 1;
    tick();
    chk("robok_we0", bus.write_enable, 1);
    chk("robok_idx0", bus.ROB_entry_index, 0);
    tick();
    chk("robok_we1", bus.write_enable, 1);
    chk("robok_idx1", bus.ROB_entry_index, 1);
    tick();
    chk("robok_done", bus.write_enable, 0);

    // 65 back-to-back dispatches: ROB index wraps.
    do_reset(1);
    idx_log.delete();
    for (int i = 0; i < 65; i++)
      push(7'h13, 6'($urandom), 6'($urandom), 6'($urandom), $urandom);
    repeat (3) tick();
    chk("wrap_count", idx_log.size(), 65);
    if (idx_log.size() == 65) begin
      chk("wrap_idx63", idx_log[63], 63);
      chk("wrap_idx64", idx_log[64], 0);
    end

    // Flush with 3 queued entries; a push offered during flush is dropped.
    bus.issue_queue_full = 1;
    push(7'h13, 6'd1, 6'd1, 6'd1, 32'd0);
    push(7'h13, 6'd2, 6'd2, 6'd2, 32'd0);
    push(7'h13, 6'd3, 6'd3, 6'd3, 32'd0);
    flush = 1;
    bus.in_valid = 1;
    bus.in_opcode = 7'h37;
    tick();
    flush = 0;
    bus.in_valid = 0;
    bus.issue_queue_full = 0;
    idx_log.delete();
    repeat (4) tick();
    chk("flush_no_write", idx_log.size(), 0);
    push(7'h17, 6'd9, 6'd2, 6'd3, 32'd77);
    chk("postflush_wait", bus.write_enable, 0);
    tick();
    chk("postflush_we", bus.write_enable, 1);
    chk("postflush_idx", bus.ROB_entry_index, 0);
    chk("postflush_op", bus.opcode, 7'h17);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      reset                = ($urandom_range(0, 99) == 0);
      flush                = ($urandom_range(0, 99) < 3);
      bus.issue_queue_full = ($urandom_range(0, 9) < 3);
      rob_alloc_ok         = ($urandom_range(0, 9) < 8);
      bus.in_valid         = ($urandom_range(0, 9) < 7);
      bus.in_opcode        = 7'($urandom);
      bus.in_phys_dest     = 6'($urandom);
      bus.in_phys_rs1      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      bus.in_phys_rs2      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      bus.in_immediate     = $urandom;
      prf_mem[$urandom_range(1, 63)] = $urandom;
      tick();
    end
    reset = 0;
    flush = 0;
    bus.issue_queue_full = 0;
    rob_alloc_ok = 1;
    bus.in_valid = 0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
